// File: rtl/joybus_pkg.sv
// Shared Joybus definitions: scheduler states, command opcodes and bit lengths.
package joybus_pkg;

  typedef enum logic [2:0] {
    HOLD,
    PROBE,
    PROBE_WAIT,
    ORIGIN,
    ORIGIN_WAIT,
    POLL,
    POLL_WAIT
  } joyState_t;

  localparam logic [7:0]  CMD_PROBE  = 8'h00;
  localparam logic [7:0]  CMD_ORIGIN = 8'h41;
  localparam logic [15:0] CMD_POLL   = 16'h4003;

  localparam logic [4:0] CMD_LEN_SHORT = 5'd8;
  localparam logic [4:0] CMD_LEN_POLL  = 5'd24;

  localparam logic [6:0] RSP_LEN_PROBE  = 7'd24;
  localparam logic [6:0] RSP_LEN_ORIGIN = 7'd80;
  localparam logic [6:0] RSP_LEN_POLL   = 7'd64;

  // Commands travel MSB-first, so short opcodes sit in the top byte.
  function automatic logic [23:0] shortCommand(input logic [7:0] opcode);
    return {opcode, 16'h0000};
  endfunction

  function automatic logic [23:0] pollCommand(input logic rumbleOn);
    return {CMD_POLL, 7'b0000000, rumbleOn};
  endfunction

endpackage

// File: rtl/joybus_timer.sv
// Loadable down-counter that parks at zero; zero is reported as expired.
module joybus_timer #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] loadValue,
  output logic             expired
);

  logic [WIDTH-1:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load) begin
      count <= loadValue;
    end else if (count != '0) begin
      count <= count - WIDTH'(1);
    end
  end

  assign expired = (count == '0);

endmodule

// File: rtl/joybus_poll_scheduler.sv
// Joybus controller scheduler: probes, initialises and then periodically polls a pad,
// tracking consecutive misses to detect disconnection.
module joybus_poll_scheduler
  import joybus_pkg::*;
#(
  parameter int POLL_PERIOD    = 165000,
  parameter int TIMEOUT_CYCLES = 20000,
  parameter int MAX_MISSES     = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable,
  input  logic        rumble,
  output logic        cmd_valid,
  input  logic        cmd_ready,
  output logic [23:0] cmd_data,
  output logic [4:0]  cmd_len,
  output logic [6:0]  rsp_len,
  input  logic        rsp_done,
  input  logic        rsp_err,
  input  logic [79:0] rsp_data,
  output logic [63:0] pad_data,
  output logic        pad_valid,
  output logic [79:0] origin_data,
  output logic        connected
);

  localparam int PERIOD_W  = $clog2(POLL_PERIOD) + 1;
  localparam int TIMEOUT_W = $clog2(TIMEOUT_CYCLES) + 1;
  localparam int MISS_W    = $clog2(MAX_MISSES) + 1;

  // The period timer reloads at the handshake and HOLD needs one cycle to re-issue,
  // so loading PERIOD-2 makes handshake-to-handshake spacing exactly POLL_PERIOD.
  localparam logic [PERIOD_W-1:0]  PERIOD_LOAD  = PERIOD_W'((POLL_PERIOD >= 2) ? POLL_PERIOD - 2 : 0);
  localparam logic [TIMEOUT_W-1:0] TIMEOUT_LOAD = TIMEOUT_W'((TIMEOUT_CYCLES >= 1) ? TIMEOUT_CYCLES - 1 : 0);
  localparam logic [MISS_W-1:0]    MISS_LIMIT   = MISS_W'(MAX_MISSES);

  joyState_t         state;
  logic              probeOk;
  logic [MISS_W-1:0] missCount;
  logic [MISS_W-1:0] missNext;
  logic              handshake;
  logic              periodExpired;
  logic              timeoutExpired;

  assign handshake = cmd_valid && cmd_ready;

  joybus_timer #(.WIDTH(PERIOD_W)) periodTimer (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (handshake),
    .loadValue (PERIOD_LOAD),
    .expired   (periodExpired)
  );

  joybus_timer #(.WIDTH(TIMEOUT_W)) timeoutTimer (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (handshake),
    .loadValue (TIMEOUT_LOAD),
    .expired   (timeoutExpired)
  );

  always_comb begin
    missNext = missCount;
    if (missCount < MISS_LIMIT) begin
      missNext = missCount + MISS_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= HOLD;
      cmd_valid   <= 1'b0;
      cmd_data    <= '0;
      cmd_len     <= '0;
      rsp_len     <= '0;
      probeOk     <= 1'b0;
      missCount   <= '0;
      connected   <= 1'b0;
      pad_data    <= '0;
      pad_valid   <= 1'b0;
      origin_data <= '0;
    end else begin
      pad_valid <= 1'b0;
      case (state)
        HOLD: begin
          if (periodExpired && enable) begin
            cmd_valid <= 1'b1;
            if (connected) begin
              state    <= POLL;
              cmd_data <= pollCommand(rumble);
              cmd_len  <= CMD_LEN_POLL;
              rsp_len  <= RSP_LEN_POLL;
            end else if (probeOk) begin
              state    <= ORIGIN;
              cmd_data <= shortCommand(CMD_ORIGIN);
              cmd_len  <= CMD_LEN_SHORT;
              rsp_len  <= RSP_LEN_ORIGIN;
            end else begin
              state    <= PROBE;
              cmd_data <= shortCommand(CMD_PROBE);
              cmd_len  <= CMD_LEN_SHORT;
              rsp_len  <= RSP_LEN_PROBE;
            end
          end
        end
        PROBE: begin
          if (cmd_ready) begin
            cmd_valid <= 1'b0;
            state     <= PROBE_WAIT;
          end
        end
        ORIGIN: begin
          if (cmd_ready) begin
            cmd_valid <= 1'b0;
            state     <= ORIGIN_WAIT;
          end
        end
        POLL: begin
          if (cmd_ready) begin
            cmd_valid <= 1'b0;
            state     <= POLL_WAIT;
          end
        end
        // A response in the terminal timeout cycle wins over the timeout.
        PROBE_WAIT: begin
          if (rsp_done) begin
            state   <= HOLD;
            probeOk <= !rsp_err;
          end else if (timeoutExpired) begin
            state   <= HOLD;
            probeOk <= 1'b0;
          end
        end
        ORIGIN_WAIT: begin
          if (rsp_done || timeoutExpired) begin
            state   <= HOLD;
            probeOk <= 1'b0;
            if (rsp_done && !rsp_err) begin
              origin_data <= rsp_data;
              connected   <= 1'b1;
              missCount   <= '0;
            end
          end
        end
        POLL_WAIT: begin
          if (rsp_done && !rsp_err) begin
            state     <= HOLD;
            pad_data  <= rsp_data[79:16];
            pad_valid <= 1'b1;
            missCount <= '0;
          end else if (rsp_done || timeoutExpired) begin
            state     <= HOLD;
            missCount <= missNext;
            if (missNext >= MISS_LIMIT) begin
              connected <= 1'b0;
            end
          end
        end
        default: begin
          state     <= HOLD;
          cmd_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_joybus_poll_scheduler.sv
// Directed bench for joybus_poll_scheduler: a table of transactions plus reset and enable sequences.
module tb_joybus_poll_scheduler;

  localparam int P  = 40;
  localparam int TO = 48;
  localparam int K_NONE = 0;
  localparam int K_OK   = 1;
  localparam int K_ERR  = 2;

  typedef struct {
    bit          rumble;
    int          readyDelay;
    int          rspKind;
    int          rspDelay;
    logic [79:0] rspData;
    logic [23:0] expCmd;
    logic [4:0]  expLen;
    logic [6:0]  expRspLen;
    bit          expConn;
    bit          expPadValid;
    logic [63:0] expPad;
    int          expDelta;
    bit          dropEnable;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        enable;
  logic        rumble;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [23:0] cmd_data;
  logic [4:0]  cmd_len;
  logic [6:0]  rsp_len;
  logic        rsp_done;
  logic        rsp_err;
  logic [79:0] rsp_data;
  logic [63:0] pad_data;
  logic        pad_valid;
  logic [79:0] origin_data;
  logic        connected;

  int checks = 0;
  int failures = 0;
  int cycleCount = 0;
  int lastHs = 0;
  int pulseCount = 0;
  int expPulses = 0;
  logic [79:0] expOrigin = '0;
  vec_t vectors[16];

  joybus_poll_scheduler #(
    .POLL_PERIOD    (P),
    .TIMEOUT_CYCLES (TO),
    .MAX_MISSES     (3)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .enable      (enable),
    .rumble      (rumble),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_data    (cmd_data),
    .cmd_len     (cmd_len),
    .rsp_len     (rsp_len),
    .rsp_done    (rsp_done),
    .rsp_err     (rsp_err),
    .rsp_data    (rsp_data),
    .pad_data    (pad_data),
    .pad_valid   (pad_valid),
    .origin_data (origin_data),
    .connected   (connected)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cycleCount++;

  always @(negedge clk) begin
    if (rst_n && pad_valid) pulseCount++;
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [79:0] actual, input logic [79:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%h required=%h", name, actual, expected);
    end
  endtask

  task automatic waitCommand(output bit seen);
    int n = 0;
    while (!cmd_valid && n < 200) begin
      @(negedge clk);
      n++;
    end
    seen = cmd_valid;
  endtask

  task automatic applyStimulus(input vec_t v);
    bit seen;
    bit stable;
    int delay;
    rumble = v.rumble;
    waitCommand(seen);
    if (!seen) begin
      checkOutput("cmdIssueTimeout", 80'(0), 80'(1));
      return;
    end
    checkOutput("cmdData", 80'(cmd_data), 80'(v.expCmd));
    checkOutput("cmdLen", 80'(cmd_len), 80'(v.expLen));
    checkOutput("rspLen", 80'(rsp_len), 80'(v.expRspLen));
    stable = 1'b1;
    for (int i = 0; i < v.readyDelay; i++) begin
      @(negedge clk);
      if (cmd_valid !== 1'b1 || cmd_data !== v.expCmd || cmd_len !== v.expLen || rsp_len !== v.expRspLen)
        stable = 1'b0;
    end
    if (v.readyDelay > 0) checkOutput("cmdStable", 80'(stable), 80'(1));
    cmd_ready = 1'b1;
    if (v.expDelta != 0) checkOutput("issueSpacing", 80'(cycleCount - lastHs), 80'(v.expDelta));
    lastHs = cycleCount;
    @(negedge clk);
    cmd_ready = 1'b0;
    if (v.dropEnable) enable = 1'b0;
    checkOutput("validDrop", 80'(cmd_valid), 80'(0));
    delay = (v.rspKind == K_NONE) ? TO - 1 : v.rspDelay;
    repeat (delay) @(negedge clk);
    if (v.rspKind != K_NONE) begin
      rsp_done = 1'b1;
      rsp_err  = (v.rspKind == K_ERR);
      rsp_data = v.rspData;
    end
    @(negedge clk);
    rsp_done = 1'b0;
    rsp_err  = 1'b0;
    if (v.expCmd == 24'h410000 && v.rspKind == K_OK) expOrigin = v.rspData;
    if (v.expPadValid) expPulses++;
    checkOutput("connected", 80'(connected), 80'(v.expConn));
    checkOutput("padValid", 80'(pad_valid), 80'(v.expPadValid));
    checkOutput("padData", 80'(pad_data), 80'(v.expPad));
    checkOutput("originData", origin_data, expOrigin);
  endtask

  initial begin
    vec_t extra;
    bit seen;
    bit sawValid;
    rst_n = 1'b0; enable = 1'b0; rumble = 1'b0; cmd_ready = 1'b0;
    rsp_done = 1'b0; rsp_err = 1'b0; rsp_data = '0;

    vectors[0]  = '{0, 0,  K_OK,   3, 80'h0500_0200_0000_0000_0000, 24'h000000, 5'd8,  7'd24, 0, 0, 64'h0, 0, 0};
    vectors[1]  = '{0, 0,  K_OK,   5, 80'hA1B2_C3D4_E5F6_0718_293A, 24'h410000, 5'd8,  7'd80, 1, 0, 64'h0, P, 0};
    vectors[2]  = '{0, 0,  K_OK,   4, {64'h0123_4567_89AB_CDEF, 16'h0}, 24'h400300, 5'd24, 7'd64, 1, 1, 64'h0123_4567_89AB_CDEF, P, 0};
    vectors[3]  = '{1, 50, K_OK,   2, {64'hFEDC_BA98_7654_3210, 16'hBEEF}, 24'h400301, 5'd24, 7'd64, 1, 1, 64'hFEDC_BA98_7654_3210, 0, 0};
    vectors[4]  = '{0, 0,  K_NONE, 0, 80'h0, 24'h400300, 5'd24, 7'd64, 1, 0, 64'hFEDC_BA98_7654_3210, P, 0};
    vectors[5]  = '{0, 0,  K_NONE, 0, 80'h0, 24'h400300, 5'd24, 7'd64, 1, 0, 64'hFEDC_BA98_7654_3210, TO + 2, 0};
    vectors[6]  = '{0, 0,  K_OK,   TO - 1, {64'h1122_3344_5566_7788, 16'h0}, 24'h400300, 5'd24, 7'd64, 1, 1, 64'h1122_3344_5566_7788, TO + 2, 0};
    vectors[7]  = '{0, 0,  K_NONE, 0, 80'h0, 24'h400300, 5'd24, 7'd64, 1, 0, 64'h1122_3344_5566_7788, TO + 2, 0};
    vectors[8]  = '{0, 0,  K_ERR,  2, 80'hFFFF_FFFF_FFFF_FFFF_FFFF, 24'h400300, 5'd24, 7'd64, 1, 0, 64'h1122_3344_5566_7788, TO + 2, 0};
    vectors[9]  = '{0, 0,  K_NONE, 0, 80'h0, 24'h400300, 5'd24, 7'd64, 0, 0, 64'h1122_3344_5566_7788, P, 0};
    vectors[10] = '{0, 0,  K_ERR,  1, 80'h0, 24'h000000, 5'd8,  7'd24, 0, 0, 64'h1122_3344_5566_7788, TO + 2, 0};
    vectors[11] = '{0, 0,  K_OK,   3, 80'h0500_0200_0000_0000_0000, 24'h000000, 5'd8,  7'd24, 0, 0, 64'h1122_3344_5566_7788, P, 0};
    vectors[12] = '{0, 0,  K_NONE, 0, 80'h0, 24'h410000, 5'd8,  7'd80, 0, 0, 64'h1122_3344_5566_7788, P, 0};
    vectors[13] = '{0, 0,  K_OK,   3, 80'h0500_0200_0000_0000_0000, 24'h000000, 5'd8,  7'd24, 0, 0, 64'h1122_3344_5566_7788, TO + 2, 0};
    vectors[14] = '{0, 0,  K_OK,   6, 80'h0F1E_2D3C_4B5A_6978_8796, 24'h410000, 5'd8,  7'd80, 1, 0, 64'h1122_3344_5566_7788, P, 0};
    vectors[15] = '{0, 0,  K_OK,   3, {64'hCAFE_F00D_DEAD_BEEF, 16'h1234}, 24'h400300, 5'd24, 7'd64, 1, 1, 64'hCAFE_F00D_DEAD_BEEF, P, 0};

    repeat (3) @(negedge clk);
    checkOutput("resetCmdValid", 80'(cmd_valid), 80'(0));
    checkOutput("resetConnected", 80'(connected), 80'(0));
    checkOutput("resetPadValid", 80'(pad_valid), 80'(0));
    checkOutput("resetPadData", 80'(pad_data), 80'(0));
    checkOutput("resetOrigin", origin_data, 80'(0));
    rst_n = 1'b1;
    enable = 1'b1;

    for (int i = 0; i < 16; i++) applyStimulus(vectors[i]);

    // Disable mid-poll: the poll completes, then nothing issues until re-enabled.
    extra = '{0, 0, K_OK, 3, {64'h5555_AAAA_5555_AAAA, 16'h0}, 24'h400300, 5'd24, 7'd64, 1, 1, 64'h5555_AAAA_5555_AAAA, P, 1};
    applyStimulus(extra);
    sawValid = 1'b0;
    repeat (120) begin
      @(negedge clk);
      if (cmd_valid) sawValid = 1'b1;
    end
    checkOutput("holdWhileDisabled", 80'(sawValid), 80'(0));
    enable = 1'b1;
    extra = '{0, 0, K_OK, 2, {64'h0F0F_0F0F_F0F0_F0F0, 16'h0}, 24'h400300, 5'd24, 7'd64, 1, 1, 64'h0F0F_0F0F_F0F0_F0F0, 0, 0};
    applyStimulus(extra);

    // Reset while a poll is outstanding, then a stray response.
    waitCommand(seen);
    checkOutput("preResetPoll", 80'(seen), 80'(1));
    cmd_ready = 1'b1;
    @(negedge clk);
    cmd_ready = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    enable = 1'b0;
    #1;
    checkOutput("asyncCmdValid", 80'(cmd_valid), 80'(0));
    checkOutput("asyncConnected", 80'(connected), 80'(0));
    checkOutput("asyncPadData", 80'(pad_data), 80'(0));
    checkOutput("asyncOrigin", origin_data, 80'(0));
    expOrigin = '0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    rsp_done = 1'b1;
    rsp_data = {64'h9999_8888_7777_6666, 16'h0};
    @(negedge clk);
    rsp_done = 1'b0;
    checkOutput("strayConnected", 80'(connected), 80'(0));
    checkOutput("strayPadValid", 80'(pad_valid), 80'(0));
    checkOutput("strayPadData", 80'(pad_data), 80'(0));
    enable = 1'b1;
    extra = '{0, 0, K_OK, 3, 80'h0500_0200_0000_0000_0000, 24'h000000, 5'd8, 7'd24, 0, 0, 64'h0, 0, 0};
    applyStimulus(extra);

    checkOutput("padPulseCount", 80'(pulseCount), 80'(expPulses));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
